spi_batch_sched: RTL and testbench
==================================

Name: spi_batch_sched

Overview:
- Round-robin scheduler that shares one spi_ctlr between NUM_REQ requesters.
- Each requester streams a batch of (slave addr, slave data) byte pairs.
- For each batch, the block acts as the APB master of spi_ctlr:
  - writes address registers 0x00+i and data registers 0x10+i;
  - writes CTRL (0x20) with {count-1, start=1};
  - polls CTRL until bit0 reads 0, then signals completion to the owning requester.
- Sits between the system request fabric and spi_ctlr's APB port.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- MAX_TXS, 8: maximum pairs per batch; must match spi_ctlr.
- ADDR_WIDTH, 8: APB address width.
- DATA_WIDTH, 8: APB data width and pair field width.
- POLL_GAP, 4: idle cycles between consecutive CTRL polls.
- POLL_TIMEOUT, 256: maximum polls before the batch is declared failed.

Ports:
- pclk_i  in  1  clock
- prst_i  in  1  asynchronous reset, active-low
- req_valid_i  in  NUM_REQ  per-requester pair valid
- req_addr_i  in  NUM_REQ*DATA_WIDTH  pair address byte; requester r occupies slice [r*8+:8]
- req_data_i  in  NUM_REQ*DATA_WIDTH  pair data byte
- req_last_i  in  NUM_REQ  marks the final pair of a batch
- req_ready_o  out  NUM_REQ  pair accepted when valid&ready at posedge
- done_o  out  NUM_REQ  1-cycle pulse: batch completed
- err_o  out  NUM_REQ  1-cycle pulse: batch aborted (pslverr or timeout)
- m_paddr_o  out  ADDR_WIDTH  APB address
- m_pwdata_o  out  DATA_WIDTH  APB write data
- m_pwrite_o  out  1  APB write
- m_penable_o  out  1  APB enable
- m_prdata_i  in  DATA_WIDTH  APB read data
- m_pready_i  in  1  APB ready
- m_pslverr_i  in  1  APB error

Behaviour:
- Reset:
  - All outputs are 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
  - FSM = IDLE; pair index = 0.
  - Reset assertion mid-operation aborts immediately and asynchronously: m_penable_o drops and no done/err pulse is issued.
- APB access (spi_ctlr protocol, no psel):
  - Drive paddr/pwdata/pwrite with penable=1 and hold them until m_pready_i is sampled high at a posedge.
  - In the next cycle penable=0, pwrite=0, paddr=0, pwdata=0.
  - At least one idle cycle separates accesses.
  - m_pslverr_i is sampled together with m_pready_i.
- Arbitration:
  - In IDLE, grant the first requester with req_valid_i high, searching from pointer+1 modulo NUM_REQ.
  - Pointer is updated to the winner.
  - Grant is held until done or err for that batch; other requesters see ready=0 throughout.
- FSM states: IDLE, ACCEPT, WR_ADDR, WR_DATA, START, POLL_GAP, POLL, FINISH.
  - IDLE -> ACCEPT on grant.
  - ACCEPT:
    - req_ready_o[grant]=1 for exactly one cycle per pair.
    - On handshake, capture the pair and go to WR_ADDR; ready drops.
    - If valid is low, stay in ACCEPT with ready held.
  - WR_ADDR: write (idx, pair addr) -> WR_DATA.
  - WR_DATA: write (0x10+idx, pair data).
    - If last was captured or idx==MAX_TXS-1 -> START.
    - Otherwise idx+1 -> ACCEPT.
  - START: write (0x20, {idx[2:0], 1'b1}), i.e. count-1 in bits [3:1] -> POLL_GAP.
  - POLL_GAP: wait POLL_GAP cycles -> POLL.
  - POLL: read 0x20.
    - prdata[0]==0 -> FINISH.
    - Otherwise increment poll count -> POLL_GAP.
  - FINISH:
    - done_o[grant] pulses 1 cycle.
    - idx and poll count cleared.
    - -> IDLE; next grant is evaluated the cycle after.
- Overflow: if MAX_TXS pairs arrive without last, the batch is forced closed after the 8th. Subsequent pairs from the same requester form a new batch, arbitrated normally.
- Error:
  - m_pslverr_i on any write aborts the batch: no START write, err_o[grant] pulses, -> IDLE.
  - pslverr on a poll read is treated the same way.
- Simultaneous requests: only the round-robin winner gets ready; losers' valid stays pending and is never dropped.

Optional Feature:
- Macro: SPI_BATCH_SCHED_TIMEOUT_EN.
- Defined: after POLL_TIMEOUT polls with bit0 still 1, err_o[grant] pulses and FSM -> IDLE. spi_ctlr is left as-is.
- Undefined: no poll counter logic; POLL repeats indefinitely until bit0 reads 0.

Test Plan:
1. Single batch: requester 0 sends 3 pairs (D3/46, D4/47, D5/48, last on the 3rd). Required response:
   - APB writes in order: 0x00=D3, 0x10=46, 0x01=D4, 0x11=47, 0x02=D5, 0x12=48, 0x20=0x05.
   - Polls until model clears bit0, then done_o[0] pulses once.
2. Round-robin: both requesters valid in the same cycle after reset, each with 1 pair. Required response:
   - Requester 0 is served first; CTRL=0x01 for both batches.
   - Requester 1 is served next; done_o[0] precedes done_o[1].
   - With 0 re-requesting, 1 is still served before 0's second batch.
3. Overflow: requester 1 sends 10 pairs with last on the 10th. Required response:
   - First batch writes idx 0..7 and CTRL=0x0F, then done.
   - Second batch writes idx 0..1 and CTRL=0x03, then done.
4. Slave error: model asserts pslverr on the write to 0x11. Required response:
   - No further writes, no CTRL write.
   - err_o pulses; next requester is granted.
5. Timeout (macro defined, POLL_TIMEOUT=4): model never clears bit0. Required response: exactly 4 reads of 0x20, then err_o pulses.
6. Reset mid-batch: prst_i low during WR_DATA wait-state. Required response:
   - m_penable_o and all outputs are 0 asynchronously.
   - After release, requester 0 is granted first.

Source files
------------

// File: rtl/spi_batch_sched.sv
// spi_batch_sched: round-robin APB master that packs requester (addr, data) byte pairs into spi_ctlr batches.
// Optional poll timeout: define SPI_BATCH_SCHED_TIMEOUT_EN.
module spi_batch_sched #(
    parameter int NUM_REQ      = 2,
    parameter int MAX_TXS      = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int POLL_GAP     = 4,
    parameter int POLL_TIMEOUT = 256
) (
    input  logic                          pclk_i,
    input  logic                          prst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic [NUM_REQ-1:0]            err_o,
    output logic [ADDR_WIDTH-1:0]         m_paddr_o,
    output logic [DATA_WIDTH-1:0]         m_pwdata_o,
    output logic                          m_pwrite_o,
    output logic                          m_penable_o,
    input  logic [DATA_WIDTH-1:0]         m_prdata_i,
    input  logic                          m_pready_i,
    input  logic                          m_pslverr_i
);
    localparam int IW  = MAX_TXS > 1 ? $clog2(MAX_TXS) : 1;
    localparam int RW  = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int GW  = $clog2(POLL_GAP + 1);
    typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WR_ADDR, S_WR_DATA, S_START, S_GAP, S_POLL, S_FINISH} state_t;
    state_t                state;
    logic [RW-1:0]         ptr, grant, win;
    logic                  found, poll_expired;
    logic [IW-1:0]         idx;
    logic [GW-1:0]         gap_cnt;
    logic [DATA_WIDTH-1:0] pair_addr, pair_data, acc_data;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  pair_last;
    logic [NUM_REQ-1:0]    grant_oh;
    logic                  unused_prdata;
    assign grant_oh      = NUM_REQ'(1) << grant;
    assign unused_prdata = ^m_prdata_i[DATA_WIDTH-1:1];
    // Highest offset first so the nearest requester after ptr wins last.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid_i[(int'(ptr) + k) % NUM_REQ]) begin
                win   = RW'((int'(ptr) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        acc_addr = state == S_WR_ADDR ? ADDR_WIDTH'(idx) :
                   state == S_WR_DATA ? ADDR_WIDTH'(idx) + ADDR_WIDTH'('h10) : ADDR_WIDTH'('h20);
        acc_data = state == S_WR_ADDR ? pair_addr :
                   state == S_WR_DATA ? pair_data :
                   state == S_START   ? DATA_WIDTH'({idx, 1'b1}) : '0;
    end
`ifdef SPI_BATCH_SCHED_TIMEOUT_EN
    localparam int PCW = $clog2(POLL_TIMEOUT + 1);
    logic [PCW-1:0] poll_cnt;
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i)
            poll_cnt <= '0;
        else if (state == S_POLL && m_penable_o && m_pready_i)
            poll_cnt <= poll_cnt + 1'b1;
        else if (state == S_IDLE)
            poll_cnt <= '0;
    end
    assign poll_expired = poll_cnt == PCW'(POLL_TIMEOUT - 1);
`else
    assign poll_expired = 1'b0;
`endif
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            state       <= S_IDLE;
            ptr         <= RW'(NUM_REQ - 1);
            grant       <= '0;
            idx         <= '0;
            gap_cnt     <= '0;
            pair_addr   <= '0;
            pair_data   <= '0;
            pair_last   <= 1'b0;
            req_ready_o <= '0;
            done_o      <= '0;
            err_o       <= '0;
            m_paddr_o   <= '0;
            m_pwdata_o  <= '0;
            m_pwrite_o  <= 1'b0;
            m_penable_o <= 1'b0;
        end else begin
            done_o <= '0;
            err_o  <= '0;
            case (state)
                S_IDLE: if (found) begin
                    grant       <= win;
                    ptr         <= win;
                    req_ready_o <= NUM_REQ'(1) << win;
                    state       <= S_ACCEPT;
                end
                S_ACCEPT: if (req_valid_i[grant]) begin
                    pair_addr   <= req_addr_i[grant*DATA_WIDTH +: DATA_WIDTH];
                    pair_data   <= req_data_i[grant*DATA_WIDTH +: DATA_WIDTH];
                    pair_last   <= req_last_i[grant];
                    req_ready_o <= '0;
                    state       <= S_WR_ADDR;
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt == GW'(POLL_GAP - 1) ? '0 : gap_cnt + 1'b1;
                    state   <= gap_cnt == GW'(POLL_GAP - 1) ? S_POLL : S_GAP;
                end
                S_FINISH: begin
                    idx   <= '0;
                    state <= S_IDLE;
                end
                default: if (!m_penable_o) begin
                    m_penable_o <= 1'b1;
                    m_paddr_o   <= acc_addr;
                    m_pwdata_o  <= acc_data;
                    m_pwrite_o  <= state != S_POLL;
                end else if (m_pready_i) begin
                    m_penable_o <= 1'b0;
                    m_paddr_o   <= '0;
                    m_pwdata_o  <= '0;
                    m_pwrite_o  <= 1'b0;
                    if (m_pslverr_i || (state == S_POLL && m_prdata_i[0] && poll_expired)) begin
                        err_o <= grant_oh;
                        idx   <= '0;
                        state <= S_IDLE;
                    end else if (state == S_WR_ADDR)
                        state <= S_WR_DATA;
                    else if (state == S_WR_DATA) begin
                        if (pair_last || idx == IW'(MAX_TXS - 1))
                            state <= S_START;
                        else begin
                            idx         <= idx + 1'b1;
                            req_ready_o <= grant_oh;
                            state       <= S_ACCEPT;
                        end
                    end else if (state == S_START)
                        state <= S_GAP;
                    else if (!m_prdata_i[0]) begin
                        done_o <= grant_oh;
                        state  <= S_FINISH;
                    end else
                        state <= S_GAP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_batch_sched.sv
// tb_spi_batch_sched: scoreboard bench; expected APB accesses and done/err pulses are queued, a slave/monitor pops them.
module tb_spi_batch_sched;
    logic        pclk_i = 1'b0, prst_i = 1'b0;
    logic [1:0]  req_valid_i, req_last_i, req_ready_o, done_o, err_o;
    logic [15:0] req_addr_i, req_data_i;
    logic [7:0]  m_paddr_o, m_pwdata_o, m_prdata_i;
    logic        m_pwrite_o, m_penable_o, m_pready_i, m_pslverr_i;
    logic        pv[2], pl[2];
    logic [7:0]  pa[2], pd[2];
    logic [17:0] exp_q[$];
    int          checks = 0, errors = 0, ws = 0, busy_cfg = 2, busy_left = 0;
    bit          wtog, stuck, hold_data, err_en;
    logic [7:0]  err_addr = 8'h00;
    assign req_valid_i = {pv[1], pv[0]};
    assign req_last_i  = {pl[1], pl[0]};
    assign req_addr_i  = {pa[1], pa[0]};
    assign req_data_i  = {pd[1], pd[0]};
    spi_batch_sched #(.NUM_REQ(2), .MAX_TXS(8), .ADDR_WIDTH(8), .DATA_WIDTH(8), .POLL_GAP(4), .POLL_TIMEOUT(4)) dut (
        .pclk_i(pclk_i), .prst_i(prst_i), .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
        .req_data_i(req_data_i), .req_last_i(req_last_i), .req_ready_o(req_ready_o), .done_o(done_o),
        .err_o(err_o), .m_paddr_o(m_paddr_o), .m_pwdata_o(m_pwdata_o), .m_pwrite_o(m_pwrite_o),
        .m_penable_o(m_penable_o), .m_prdata_i(m_prdata_i), .m_pready_i(m_pready_i), .m_pslverr_i(m_pslverr_i)
    );
    always #5 pclk_i = ~pclk_i;
    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic pop_check(input string name, input logic [17:0] act);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected %h with empty scoreboard", name, act);
        end else
            check(name, act, exp_q.pop_front());
    endtask
    // APB slave model + monitor: alternates 0/1 wait states, answers polls, injects pslverr.
    always @(negedge pclk_i) begin
        m_pready_i  = 1'b0;
        m_pslverr_i = 1'b0;
        m_prdata_i  = 8'h00;
        if (!prst_i) begin
            ws   = 0;
            wtog = 1'b0;
        end
        if (done_o != 0 || err_o != 0)
            pop_check("event", {done_o != 0 ? 2'd2 : 2'd3, 8'h00, 6'b0, done_o | err_o});
        if (m_penable_o && !(hold_data && m_paddr_o == 8'h10)) begin
            if (ws > 0)
                ws--;
            else begin
                ws          = int'(wtog);
                wtog        = !wtog;
                m_pready_i  = 1'b1;
                pop_check("apb", {m_pwrite_o ? 2'd0 : 2'd1, m_paddr_o, m_pwdata_o});
                if (m_pwrite_o && m_paddr_o == 8'h20)
                    busy_left = busy_cfg;
                if (!m_pwrite_o) begin
                    m_prdata_i = (stuck || busy_left > 0) ? 8'h01 : 8'h00;
                    if (busy_left > 0)
                        busy_left--;
                end
                m_pslverr_i = err_en && m_pwrite_o && m_paddr_o == err_addr;
            end
        end
    end
    task automatic send_pair(input int r, input logic [7:0] a, input logic [7:0] d, input logic l);
        pv[r] = 1'b1;
        pa[r] = a;
        pd[r] = d;
        pl[r] = l;
        for (int n = 0; n < 3000; n++) begin
            @(negedge pclk_i);
            if (req_ready_o[r])
                break;
            if (n == 2999) begin
                checks++;
                errors++;
                $display("FAIL ready_wait: requester %0d got no ready", r);
            end
        end
        @(posedge pclk_i);
        #1;
        pv[r] = 1'b0;
        pl[r] = 1'b0;
    endtask
    task automatic send_batch(input int r, input int n, input logic [7:0] ba, input logic [7:0] bd);
        for (int i = 0; i < n; i++)
            send_pair(r, ba + 8'(i), bd + 8'(i), i == n - 1);
    endtask
    task automatic exp_batch(input logic [7:0] oh, input int n, input logic [7:0] ba, input logic [7:0] bd, input logic [7:0] ctrl);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({2'd0, 8'(i), 8'(ba + 8'(i))});
            exp_q.push_back({2'd0, 8'(8'h10 + 8'(i)), 8'(bd + 8'(i))});
        end
        exp_q.push_back({2'd0, 8'h20, ctrl});
        for (int i = 0; i <= busy_cfg; i++)
            exp_q.push_back({2'd1, 8'h20, 8'h00});
        exp_q.push_back({2'd2, 8'h00, oh});
    endtask
    task automatic drain(input string name);
        for (int n = 0; n < 4000 && exp_q.size() != 0; n++)
            @(negedge pclk_i);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: %0d expected items still pending", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge pclk_i);
    endtask
    task automatic check_idle_outputs(input string name);
        check({name, "_ready"}, 18'(req_ready_o), 18'h0);
        check({name, "_pulses"}, 18'({done_o, err_o}), 18'h0);
        check({name, "_penable"}, 18'(m_penable_o), 18'h0);
        check({name, "_pwrite"}, 18'(m_pwrite_o), 18'h0);
        check({name, "_paddr"}, 18'(m_paddr_o), 18'h0);
        check({name, "_pwdata"}, 18'(m_pwdata_o), 18'h0);
    endtask
    initial begin
        pv = '{1'b0, 1'b0};
        pl = '{1'b0, 1'b0};
        pa = '{8'h00, 8'h00};
        pd = '{8'h00, 8'h00};
        repeat (3) @(negedge pclk_i);
        check_idle_outputs("reset");
        prst_i = 1'b1;
        // single 3-pair batch from requester 0
        exp_batch(8'h01, 3, 8'hD3, 8'h46, 8'h05);
        send_batch(0, 3, 8'hD3, 8'h46);
        drain("single");
        // round-robin after a fresh reset: 0, then 1, then 0 again
        prst_i = 1'b0;
        repeat (2) @(negedge pclk_i);
        prst_i = 1'b1;
        exp_batch(8'h01, 1, 8'hA1, 8'hB1, 8'h01);
        exp_batch(8'h02, 1, 8'hA2, 8'hB2, 8'h01);
        exp_batch(8'h01, 1, 8'hA3, 8'hB3, 8'h01);
        fork
            begin
                send_pair(0, 8'hA1, 8'hB1, 1'b1);
                send_pair(0, 8'hA3, 8'hB3, 1'b1);
            end
            send_pair(1, 8'hA2, 8'hB2, 1'b1);
        join
        drain("round_robin");
        // overflow: 10 pairs become batches of 8 and 2
        exp_batch(8'h02, 8, 8'h30, 8'h60, 8'h0F);
        exp_batch(8'h02, 2, 8'h38, 8'h68, 8'h03);
        send_batch(1, 10, 8'h30, 8'h60);
        drain("overflow");
        // slave error on the write to 0x11 aborts requester 0, requester 1 follows
        err_addr = 8'h11;
        err_en   = 1'b1;
        exp_q.push_back({2'd0, 8'h00, 8'h11});
        exp_q.push_back({2'd0, 8'h10, 8'h21});
        exp_q.push_back({2'd0, 8'h01, 8'h12});
        exp_q.push_back({2'd0, 8'h11, 8'h22});
        exp_q.push_back({2'd3, 8'h00, 8'h01});
        exp_batch(8'h02, 1, 8'h40, 8'h70, 8'h01);
        fork
            send_batch(0, 2, 8'h11, 8'h21);
            send_pair(1, 8'h40, 8'h70, 1'b1);
        join
        drain("slverr");
        err_en = 1'b0;
`ifdef SPI_BATCH_SCHED_TIMEOUT_EN
        // poll timeout: bit0 never clears, exactly 4 polls then err
        stuck = 1'b1;
        exp_q.push_back({2'd0, 8'h00, 8'h55});
        exp_q.push_back({2'd0, 8'h10, 8'h66});
        exp_q.push_back({2'd0, 8'h20, 8'h01});
        for (int i = 0; i < 4; i++)
            exp_q.push_back({2'd1, 8'h20, 8'h00});
        exp_q.push_back({2'd3, 8'h00, 8'h01});
        send_pair(0, 8'h55, 8'h66, 1'b1);
        drain("timeout");
        stuck = 1'b0;
`endif
        // reset while the data write of requester 0 is stalled
        hold_data = 1'b1;
        exp_q.push_back({2'd0, 8'h00, 8'hE0});
        send_pair(0, 8'hE0, 8'hE1, 1'b1);
        for (int n = 0; n < 200 && !(m_penable_o && m_paddr_o == 8'h10); n++)
            @(negedge pclk_i);
        check("midrst_stall", {2'd0, m_paddr_o, 7'b0, m_penable_o}, {2'd0, 8'h10, 8'h01});
        repeat (2) @(negedge pclk_i);
        #2;
        prst_i = 1'b0;
        #1;
        check_idle_outputs("midrst");
        check("midrst_queue", 18'(exp_q.size()), 18'h0);
        exp_q.delete();
        hold_data = 1'b0;
        repeat (3) @(negedge pclk_i);
        check("midrst_nopulse", 18'({done_o, err_o}), 18'h0);
        prst_i = 1'b1;
        exp_batch(8'h01, 1, 8'hC0, 8'hC1, 8'h01);
        exp_batch(8'h02, 1, 8'hC2, 8'hC3, 8'h01);
        fork
            send_pair(0, 8'hC0, 8'hC1, 1'b1);
            send_pair(1, 8'hC2, 8'hC3, 1'b1);
        join
        drain("post_reset");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
